// File: rtl/mips_pkg.sv
// Shared MIPS-32 definitions: reset vector, opcode field values and
// the fetch-queue entry bundle.
package mips_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order {instr, pc} buffer between fetch and decode.
// Head is held in slot0; an empty queue presents all zeros.
module fetch_queue
   import mips_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output logic         head_valid,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t slot0;
   fetch_entry_t slot1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= 2'd0;
         slot0 <= '0;
         slot1 <= '0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) slot0 <= push_data;
               else               slot1 <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  slot0 <= push_data;
               end else begin
                  slot0 <= slot1;
                  slot1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_valid = (count != 2'd0);
   assign head       = head_valid ? slot0 : '0;

endmodule

// File: rtl/fetch_unit.sv
// MIPS-32 instruction fetch: PC, single-outstanding imem reads,
// 2-entry instruction queue and decode-time branch/jump redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [5:0]  op,
   input  logic        instr_ready,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index
);

   import mips_pkg::*;

   logic [31:0]  fetch_pc;
   logic [31:0]  resp_pc;
   logic         outstanding;
   logic         drop;
   logic         consume;
   logic         redirect;
   logic         resp;
   logic         enqueue;
   logic [31:0]  seq_pc;
   logic [31:0]  target;
   logic [1:0]   q_count;
   logic [1:0]   q_next;
   fetch_entry_t head;
   fetch_entry_t resp_entry;

   assign consume  = instr_valid & instr_ready;
   assign redirect = consume & (jump | branch_taken);

   assign seq_pc = instr_pc + 32'd4;
   assign target = jump ? {seq_pc[31:28], jump_index, 2'b00}
                        : seq_pc + (branch_offset << 2);

   // A response racing a redirect is as stale as one already marked drop.
   assign resp    = imem_rvalid & outstanding;
   assign enqueue = resp & ~drop & ~redirect;

   always_comb begin
      q_next = 2'd0;
      if (!redirect)
         q_next = q_count - {1'b0, consume} + {1'b0, enqueue};
   end

   assign imem_req = rst_n & ~redirect
                   & (~outstanding | imem_rvalid)
                   & (q_next < 2'd2);

   assign imem_addr = fetch_pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= 1'b0;
         drop        <= 1'b0;
      end else begin
         if (resp) begin
            outstanding <= 1'b0;
            drop        <= 1'b0;
         end
         if (redirect) begin
            fetch_pc <= target;
            if (outstanding && !imem_rvalid) drop <= 1'b1;
         end else if (imem_req) begin
            resp_pc     <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
            outstanding <= 1'b1;
         end
      end
   end

   assign resp_entry = '{instr: imem_rdata, pc: resp_pc};

   fetch_queue u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (enqueue),
      .push_data  (resp_entry),
      .pop        (consume),
      .flush      (redirect),
      .head_valid (instr_valid),
      .head       (head),
      .count      (q_count)
   );

   assign instr    = head.instr;
   assign instr_pc = head.pc;
   assign op       = head.instr[31:26];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed redirect/reset
// sequences and a random run against a program-order PC model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [5:0]  op;
   logic        instr_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_offset = 32'h0;
   logic        jump = 1'b0;
   logic [25:0] jump_index = 26'h0;

   fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .op            (op),
      .instr_ready   (instr_ready),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_index    (jump_index)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int lat     = 1;

   logic [31:0] mq_addr[$];
   int          mq_due[$];

   logic        s_req;
   logic [31:0] s_addr;
   logic        s_rvalid;

   typedef struct {
      logic        rst;
      logic        ready;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   vec_t vt[13];

   function automatic logic [31:0] memw(input logic [31:0] a);
      return {a[7:2] ^ 6'h2A, a[27:2] ^ 26'h155_5555};
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock: memory answers, sample at negedge, accept request.
   task automatic tick();
      logic [31:0] a;
      int d;
      if (mq_due.size() != 0 && mq_due[0] == cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = memw(mq_addr[0]);
         a = mq_addr.pop_front();
         d = mq_due.pop_front();
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      @(negedge clk);
      s_req    = imem_req;
      s_addr   = imem_addr;
      s_rvalid = imem_rvalid;
      if (rst_n && imem_req) begin
         mq_addr.push_back(imem_addr);
         mq_due.push_back(cyc + lat);
      end
      if (rst_n && dut.u_queue.push && !dut.u_queue.pop)
         check("q_overflow", {31'd0, dut.u_queue.count == 2'd2}, 32'd0);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      instr_ready  = 1'b0;
      jump         = 1'b0;
      branch_taken = 1'b0;
      tick();
      check("req_in_reset", {31'd0, s_req}, 32'd0);
      mq_addr.delete();
      mq_due.delete();
      rst_n = 1'b1;
      cyc   = 0;
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_pc", instr_pc, 32'd0);
      check("rst_op", {26'd0, op}, 32'd0);
   endtask

   task automatic run_to(input logic [31:0] pc);
      int n = 0;
      instr_ready  = 1'b1;
      jump         = 1'b0;
      branch_taken = 1'b0;
      while (!(instr_valid && instr_pc == pc) && n < 64) begin
         tick();
         n++;
      end
      check("reach_pc", instr_pc, pc);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!instr_valid && n < 32) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      logic [31:0] exp_pc;
      logic [31:0] nxt;
      int gap;

      vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
      vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
      vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
      vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
      vt[4]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
      vt[5]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
      vt[6]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
      vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
      vt[9]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
      vt[10] = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
      vt[11] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
      vt[12] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};

      @(posedge clk);
      #1;

      lat = 1;
      for (int i = 0; i < 13; i++) begin
         if (vt[i].rst) do_reset();
         instr_ready = vt[i].ready;
         check("vec_valid", {31'd0, instr_valid}, {31'd0, vt[i].valid});
         check("vec_pc", instr_pc, vt[i].valid ? vt[i].pc : 32'd0);
         check("vec_instr", instr, vt[i].valid ? memw(vt[i].pc) : 32'd0);
         tick();
         check("vec_req", {31'd0, s_req}, {31'd0, vt[i].req});
         check("vec_addr", s_addr, vt[i].addr);
      end

      // taken branch at 0x10, offset 3 -> 0x20
      lat = 1;
      do_reset();
      run_to(32'h10);
      branch_taken  = 1'b1;
      branch_offset = 32'd3;
      tick();
      check("br_no_req", {31'd0, s_req}, 32'd0);
      branch_taken = 1'b0;
      check("br_flushed", {31'd0, instr_valid}, 32'd0);
      tick();
      check("br_req", {31'd0, s_req}, 32'd1);
      check("br_addr", s_addr, 32'h20);
      wait_valid(n);
      check("br_first_pc", instr_pc, 32'h20);
      check("br_first_instr", instr, memw(32'h20));

      // jump beats branch at 0x40
      do_reset();
      run_to(32'h40);
      jump          = 1'b1;
      branch_taken  = 1'b1;
      branch_offset = 32'd5;
      jump_index    = 26'h000_0100;
      tick();
      check("jmp_no_req", {31'd0, s_req}, 32'd0);
      jump         = 1'b0;
      branch_taken = 1'b0;
      tick();
      check("jmp_req", {31'd0, s_req}, 32'd1);
      check("jmp_addr", s_addr, 32'h400);

      // L=3: redirect while a request is outstanding
      lat = 3;
      do_reset();
      wait_valid(n);
      check("l3_first_latency", n, 4);
      check("l3_head_pc", instr_pc, 32'h0);
      instr_ready = 1'b1;
      jump        = 1'b1;
      jump_index  = 26'h40;
      tick();
      check("drop_no_req", {31'd0, s_req}, 32'd0);
      check("drop_set", {31'd0, dut.drop}, 32'd1);
      jump = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!s_req && n < 10);
      check("drop_req_delay", n, 2);
      check("drop_req_rvalid", {31'd0, s_rvalid}, 32'd1);
      check("drop_req_addr", s_addr, 32'h100);
      wait_valid(n);
      check("drop_first_pc", instr_pc, 32'h100);
      check("drop_first_instr", instr, memw(32'h100));

      // reset while one queued and one outstanding
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      check("mid_valid", {31'd0, instr_valid}, 32'd1);
      do_reset();
      tick();
      check("mid_req", {31'd0, s_req}, 32'd1);
      check("mid_addr", s_addr, 32'h0);

      // random run vs program-order model
      for (int seg = 0; seg < 6; seg++) begin
         lat = $urandom_range(1, 4);
         do_reset();
         exp_pc = 32'h0;
         gap = 0;
         for (int k = 0; k < 300; k++) begin
            instr_ready   = ($urandom_range(0, 3) != 0);
            jump          = ($urandom_range(0, 7) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_offset = 32'($urandom_range(0, 32)) - 32'd16;
            jump_index    = 26'($urandom);
            if (instr_valid) begin
               check("rnd_gap", {31'd0, gap <= 2 * lat + 4}, 32'd1);
               gap = 0;
               check("rnd_pc", instr_pc, exp_pc);
               check("rnd_instr", instr, memw(exp_pc));
               check("rnd_op", {26'd0, op}, {26'd0, memw(exp_pc) >> 26});
               if (instr_ready) begin
                  if (jump)
                     nxt = ((exp_pc + 32'd4) & 32'hF000_0000)
                         | ({6'd0, jump_index} << 2);
                  else if (branch_taken)
                     nxt = exp_pc + 32'd4 + branch_offset * 32'd4;
                  else
                     nxt = exp_pc + 32'd4;
                  exp_pc = nxt;
               end
            end else begin
               gap++;
               check("rnd_empty", instr | instr_pc | {26'd0, op}, 32'd0);
            end
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
